// File: rtl/systolic_input_feeder.sv
// ---------------------------------------------------------------------------
// systolic_input_feeder
//   West-edge feeder for the systolic array. Accepts one activation vector
//   per cycle over a valid/ready handshake and skews it so that lane r
//   reaches row r exactly r+1 cycles after acceptance. Optionally places a
//   weight-switch token ahead of a tile and drains the skew pipeline after
//   the tile's last vector.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   en           block enable; low acts as a synchronous clear
//   in_valid     upstream vector valid
//   in_ready     feeder can accept a vector this cycle
//   in_data      vector, lane r = bits [r*DATA_W +: DATA_W]
//   in_last      accepted vector is the last of its tile
//   in_swap      with in_valid in IDLE: emit a switch token before the tile
//   row_data     per-row activation, same lane packing as in_data
//   row_valid    per-row valid
//   row_switch   per-row weight-switch pulse
//   busy         a tile is in progress (streaming or draining)
//   tile_done    one-cycle pulse when the tile's last vector is on row ROWS-1
// ---------------------------------------------------------------------------
module systolic_input_feeder #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_data,
    input  logic                   in_last,
    input  logic                   in_swap,
    output logic [ROWS*DATA_W-1:0] row_data,
    output logic [ROWS-1:0]        row_valid,
    output logic [ROWS-1:0]        row_switch,
    output logic                   busy,
    output logic                   tile_done
);

    localparam int              CNT_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // The swap token occupies the request cycle itself (in_ready is already
    // low because in_swap is high), so the tile can start streaming on the
    // very next cycle and no separate register state is needed for it.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    ready_r;
    logic                    busy_r;
    logic                    tile_done_r;
    logic [ROWS-1:0]         valid_pipe_r;
    logic [ROWS-1:0]         switch_pipe_r;

    logic                    idle_s;
    logic                    accept_s;
    logic                    swap_req_s;
    logic                    inj_valid_s;
    logic                    inj_switch_s;
    logic [ROWS*DATA_W-1:0]  inj_data_s;

    // ready_r is the registered part of the handshake; the IDLE in_swap
    // gate and en are applied on top so a swap request or clear blocks
    // acceptance in the same cycle. ready_r is low for the first cycle after
    // any clear, during which the feeder ignores requests.
    assign idle_s     = (state_r == ST_IDLE);
    assign in_ready   = ready_r & en & ~(idle_s & in_swap);
    assign accept_s   = in_valid & in_ready;
    assign swap_req_s = idle_s & ready_r & en & in_valid & in_swap;

    assign busy       = busy_r;
    assign tile_done  = tile_done_r;
    assign row_valid  = valid_pipe_r;
    assign row_switch = switch_pipe_r;

    // Slot injected into the skew pipeline this cycle; data is zero unless valid.
    always_comb begin
        inj_valid_s  = accept_s;
        inj_switch_s = swap_req_s;
        if (accept_s) begin
            inj_data_s = in_data;
        end else begin
            inj_data_s = '0;
        end
    end

    // Control FSM: state, drain counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            tile_done_r <= 1'b0;
        end else if (!en) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            tile_done_r <= 1'b0;
        end else begin
            tile_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (swap_req_s) begin
                        state_r <= ST_STREAM;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else if (accept_s && in_last) begin
                        state_r     <= ST_DRAIN;
                        cnt_r       <= CNT_LOAD;
                        ready_r     <= 1'b0;
                        busy_r      <= 1'b1;
                        tile_done_r <= (ROWS == 1);
                    end else if (accept_s) begin
                        state_r <= ST_STREAM;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (accept_s && in_last) begin
                        state_r     <= ST_DRAIN;
                        cnt_r       <= CNT_LOAD;
                        ready_r     <= 1'b0;
                        tile_done_r <= (ROWS == 1);
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Counter reaches zero on the cycle the last vector sits
                    // on row ROWS-1; tile_done is registered one step early.
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r       <= cnt_r - CNT_ONE;
                        tile_done_r <= (cnt_r == CNT_ONE);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Valid and switch travel a shared shift chain; stage r feeds row r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_pipe_r  <= '0;
            switch_pipe_r <= '0;
        end else if (!en) begin
            valid_pipe_r  <= '0;
            switch_pipe_r <= '0;
        end else begin
            valid_pipe_r[0]  <= inj_valid_s;
            switch_pipe_r[0] <= inj_switch_s;
            for (int r = ROWS - 1; r > 0; r--) begin
                valid_pipe_r[r]  <= valid_pipe_r[r-1];
                switch_pipe_r[r] <= switch_pipe_r[r-1];
            end
        end
    end

    // Each lane carries only its own data through a delay line of r+1 stages.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_lane
        logic [DATA_W-1:0] dline_r [0:gr];

        // Triangular data delay line for lane gr.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= gr; k++) begin
                    dline_r[k] <= '0;
                end
            end else if (!en) begin
                for (int k = 0; k <= gr; k++) begin
                    dline_r[k] <= '0;
                end
            end else begin
                dline_r[0] <= inj_data_s[gr*DATA_W +: DATA_W];
                for (int k = 1; k <= gr; k++) begin
                    dline_r[k] <= dline_r[k-1];
                end
            end
        end

        assign row_data[gr*DATA_W +: DATA_W] = dline_r[gr];
    end

endmodule
